// File: rtl/window_mult_pipe.sv
// K x K element-wise window multiplier with per-beat pixel signedness, LAT-deep valid/ready pipeline and aligned row/col/done sideband.
// Optional macro SUM_TREE_EN appends a registered lane-sum stage (sum_o); otherwise sum_o is tied to 0.
module window_mult_pipe #(
  parameter int K   = 3,
  parameter int NI  = 8,
  parameter int NF  = 8,
  parameter int LAT = 2,
  parameter int CW  = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            sgn_i,
  input  logic [K*K*NI-1:0]               i_flat,
  input  logic [K*K*NF-1:0]               f_flat,
  input  logic [CW-1:0]                   row_in,
  input  logic [CW-1:0]                   col_in,
  input  logic                            done_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [K*K*(NI+NF)-1:0]          d_flat,
  output logic [CW-1:0]                   row_out,
  output logic [CW-1:0]                   col_out,
  output logic                            done_out,
  output logic [NI+NF+$clog2(K*K)-1:0]    sum_o
);

  localparam int N  = K * K;
  localparam int W  = NI + NF;
  localparam int SW = W + $clog2(N);

  logic           w_en;
  logic [N*W-1:0] w_prod;

  logic [LAT-1:0] r_vld;
  logic [N*W-1:0] r_dat [LAT];
  logic [CW-1:0]  r_row [LAT];
  logic [CW-1:0]  r_col [LAT];
  logic [LAT-1:0] r_done;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Both operands widened to W bits; the low W bits of the product are exact.
  for (genvar e = 0; e < N; e++) begin : g_lane
    logic [W-1:0] w_px;
    logic [W-1:0] w_fx;
    assign w_px = sgn_i ? {{NF{i_flat[e*NI+NI-1]}}, i_flat[e*NI +: NI]}
                        : {{NF{1'b0}}, i_flat[e*NI +: NI]};
    assign w_fx = {{NI{f_flat[e*NF+NF-1]}}, f_flat[e*NF +: NF]};
    assign w_prod[e*W +: W] = w_px * w_fx;
  end

  // Payload only loads behind a valid beat so outputs hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_done <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_dat[s] <= '0;
        r_row[s] <= '0;
        r_col[s] <= '0;
      end
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_dat[0]  <= w_prod;
        r_row[0]  <= row_in;
        r_col[0]  <= col_in;
        r_done[0] <= done_in;
      end
      for (int s = 1; s < LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_dat[s]  <= r_dat[s-1];
          r_row[s]  <= r_row[s-1];
          r_col[s]  <= r_col[s-1];
          r_done[s] <= r_done[s-1];
        end
      end
    end
  end

`ifdef SUM_TREE_EN
  logic [SW-1:0]  w_sum;
  logic           r_s_vld;
  logic [N*W-1:0] r_s_dat;
  logic [CW-1:0]  r_s_row;
  logic [CW-1:0]  r_s_col;
  logic           r_s_done;
  logic [SW-1:0]  r_s_sum;

  always_comb begin
    w_sum = '0;
    for (int e = 0; e < N; e++) begin
      w_sum = w_sum + SW'($signed(r_dat[LAT-1][e*W +: W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_vld  <= 1'b0;
      r_s_dat  <= '0;
      r_s_row  <= '0;
      r_s_col  <= '0;
      r_s_done <= 1'b0;
      r_s_sum  <= '0;
    end else if (w_en) begin
      r_s_vld <= r_vld[LAT-1];
      if (r_vld[LAT-1]) begin
        r_s_dat  <= r_dat[LAT-1];
        r_s_row  <= r_row[LAT-1];
        r_s_col  <= r_col[LAT-1];
        r_s_done <= r_done[LAT-1];
        r_s_sum  <= w_sum;
      end
    end
  end

  assign out_valid = r_s_vld;
  assign d_flat    = r_s_dat;
  assign row_out   = r_s_row;
  assign col_out   = r_s_col;
  assign done_out  = r_s_done;
  assign sum_o     = r_s_sum;
`else
  assign out_valid = r_vld[LAT-1];
  assign d_flat    = r_dat[LAT-1];
  assign row_out   = r_row[LAT-1];
  assign col_out   = r_col[LAT-1];
  assign done_out  = r_done[LAT-1];
  assign sum_o     = '0;
`endif

endmodule

// File: tb/tb_window_mult_pipe.sv
// Bench for window_mult_pipe: directed steps plus a short random phase, checked against a scoreboard of modelled beats.
module tb_window_mult_pipe;
  localparam int K   = 3;
  localparam int NI  = 8;
  localparam int NF  = 8;
  localparam int LAT = 2;
  localparam int CW  = 5;
  localparam int N   = K * K;
  localparam int W   = NI + NF;
  localparam int SW  = W + $clog2(N);
`ifdef SUM_TREE_EN
  localparam int L = LAT + 1;
`else
  localparam int L = LAT;
`endif

  typedef struct packed {
    logic [N*W-1:0] d;
    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic           done;
    logic [SW-1:0]  sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, sgn_i = 1'b0;
  logic [N*NI-1:0] i_flat = '0;
  logic [N*NF-1:0] f_flat = '0;
  logic [CW-1:0] row_in = '0, col_in = '0;
  logic done_in = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [N*W-1:0] d_flat;
  logic [CW-1:0] row_out, col_out;
  logic done_out;
  logic [SW-1:0] sum_o;

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  exp_t sb[$];

  window_mult_pipe #(.K(K), .NI(NI), .NF(NF), .LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sgn_i(sgn_i),
    .i_flat(i_flat), .f_flat(f_flat), .row_in(row_in), .col_in(col_in), .done_in(done_in),
    .out_valid(out_valid), .out_ready(out_ready), .d_flat(d_flat), .row_out(row_out),
    .col_out(col_out), .done_out(done_out), .sum_o(sum_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic sgn, input logic [N*NI-1:0] iv, input logic [N*NF-1:0] fv,
                                 input logic [CW-1:0] r, input logic [CW-1:0] c, input logic dn);
    exp_t m;
    int s;
    int p, f, pr;
    m = '0;
    s = 0;
    for (int e = 0; e < N; e++) begin
      p = sgn ? int'($signed(iv[e*NI +: NI])) : int'(iv[e*NI +: NI]);
      f = int'($signed(fv[e*NF +: NF]));
      pr = p * f;
      m.d[e*W +: W] = pr[W-1:0];
      s += pr;
    end
    m.row = r;
    m.col = c;
    m.done = dn;
`ifdef SUM_TREE_EN
    m.sum = s[SW-1:0];
`else
    m.sum = '0;
`endif
    return m;
  endfunction

  // Scoreboard: pop/compare on output transfer, push on acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("d_flat", d_flat, e.d);
          check("row_out", row_out, e.row);
          check("col_out", col_out, e.col);
          check("done_out", done_out, e.done);
          check("sum_o", sum_o, e.sum);
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(sgn_i, i_flat, f_flat, row_in, col_in, done_in));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sgn, input logic [7:0] iv, input logic [7:0] fv,
                       input logic [CW-1:0] r, input logic [CW-1:0] c, input logic dn);
    in_valid = 1'b1;
    sgn_i = sgn;
    for (int e = 0; e < N; e++) begin
      i_flat[e*NI +: NI] = iv;
      f_flat[e*NF +: NF] = fv;
    end
    row_in = r;
    col_in = c;
    done_in = dn;
  endtask

  task automatic wait_out(input string tag, input int max_cycles);
    int c;
    c = 0;
    while (!out_valid && c < max_cycles) begin
      tick();
      c++;
    end
    if (!out_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic drain(input int target, input int max_cycles);
    int c;
    c = 0;
    out_ready = 1'b1;
    while (n_out < target && c < max_cycles) begin
      tick();
      c++;
    end
    check("drain_count", n_out, target);
  endtask

  initial begin
    logic [N*W-1:0] lanes;
    logic [N*W-1:0] held;
    int base;
    int seen;

    // 1. reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_d_flat", d_flat, 0);
    check("rst_row", row_out, 0);
    check("rst_col", col_out, 0);
    check("rst_done", done_out, 0);
    check("rst_sum", sum_o, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // 2. unsigned pixel, latency
    out_ready = 1'b1;
    tick();
    drive(1'b0, 8'hFF, 8'hFF, '0, '0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < L; c++) begin
      check("lat_early", out_valid, 0);
      tick();
    end
    check("lat_valid", out_valid, 1);
    lanes = {N{16'hFF01}};
    check("unsigned_lanes", d_flat, lanes);
    tick();
    check("bubble_valid", out_valid, 0);
    check("hold_d_flat", d_flat, lanes);

    // 3. signed pixel, then alternating modes back to back
    drive(1'b1, 8'hFF, 8'hFF, '0, '0, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_out("signed", 10);
    lanes = {N{16'h0001}};
    check("signed_lanes", d_flat, lanes);
    for (int b = 0; b < 4; b++) begin
      drive(b[0], 8'h80 + 8'(b), 8'hF3 - 8'(b), '0, '0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    drain(6, 20);

    // 4. four beats with a 3-cycle stall mid-stream
    base = n_out;
    drive(1'b0, 8'd1, 8'd2, '0, '0, 1'b0);
    tick();
    drive(1'b0, 8'd2, 8'd2, '0, '0, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b0, 8'd3, 8'd2, '0, '0, 1'b0);
    #1;
    held = d_flat;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_hold", d_flat, held);
    end
    out_ready = 1'b1;
    tick();
    drive(1'b0, 8'd4, 8'd2, '0, '0, 1'b0);
    tick();
    in_valid = 1'b0;
    drain(base + 4, 20);

    // 5. sideband on one beat among bubbles
    tick();
    tick();
    drive(1'b0, 8'd7, 8'd9, 5'd17, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_out("sideband", 10);
    check("sb_row", row_out, 17);
    check("sb_col", col_out, 3);
    check("sb_done", done_out, 1);
    tick();
    drive(1'b0, 8'd5, 8'd5, 5'd0, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_out("sideband_next", 10);
    check("sb_next_done", done_out, 0);
    tick();

    // Sum over lanes 1..9 with unit filter
    for (int e = 0; e < N; e++) begin
      i_flat[e*NI +: NI] = 8'(e + 1);
      f_flat[e*NF +: NF] = 8'd1;
    end
    in_valid = 1'b1;
    sgn_i = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < L; c++) begin
      check("sum_lat_early", out_valid, 0);
      tick();
    end
    check("sum_lat", out_valid, 1);
`ifdef SUM_TREE_EN
    check("sum_45", sum_o, 45);
`endif
    tick();

    // Random traffic with random backpressure
    base = n_out + sb.size();
    for (int c = 0; c < 60; c++) begin
      drive(1'($urandom), 8'($urandom), 8'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) base++;
      tick();
    end
    in_valid = 1'b0;
    drain(base, 40);
    check("sb_empty", sb.size(), 0);

    // 6. reset with two beats in flight
    drive(1'b1, 8'h12, 8'h34, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b0, 8'h56, 8'h78, 5'd3, 5'd4, 1'b0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_d_flat", d_flat, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("no_ghost_beats", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
